// File: rtl/turbo_frame_packer_if.sv
// Symbol-in / byte-out bundle for turbo_frame_packer.
//   sym_valid, sym, rate_half : encoded symbol stream into the packer
//   out_data, out_valid,
//   out_last, out_ready       : FWFT byte stream out of the packer
//   frame_done, overflow,
//   fifo_count                : status
// Modport slave is the packer itself; master is the environment that feeds
// symbols and consumes bytes.
interface turbo_frame_packer_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic            sym_valid;
    logic [2:0]      sym;
    logic            rate_half;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;
    logic            frame_done;
    logic            overflow;
    logic [CntW-1:0] fifo_count;

    modport master (
        output sym_valid, sym, rate_half, out_ready,
        input  out_data, out_valid, out_last, frame_done, overflow, fifo_count
    );

    modport slave (
        input  sym_valid, sym, rate_half, out_ready,
        output out_data, out_valid, out_last, frame_done, overflow, fifo_count
    );
endinterface

// File: rtl/turbo_frame_packer.sv
// Turbo encoder output stage: punctures 3-bit symbols ({p2, p1, sys}) to rate
// 1/3 or 1/2, packs the surviving bits MSB-first into bytes and queues them in
// a first-word-fall-through FIFO tagged with an end-of-frame flag.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : turbo_frame_packer_if.slave (symbol input, byte output, status)
module turbo_frame_packer #(
    parameter int unsigned FRAME_SYMS = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    turbo_frame_packer_if.slave bus
);
    localparam int unsigned IdxW = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e          state_q;
    logic [IdxW-1:0] idx_q;
    logic            rate_q;
    logic [7:0]      acc_q;
    logic [2:0]      fill_q;
    logic            flush_q;
    logic [7:0]      flush_data_q;
    logic            frame_done_q;

    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q;

    // Datapath for the symbol presented this cycle
    logic        rate_eff;
    logic [2:0]  ebits;
    logic [3:0]  nbits;
    logic [15:0] ins;
    logic [15:0] wide;
    logic [3:0]  total;
    logic        byte_full;
    logic        last_sym;

    logic        push;
    logic [7:0]  push_data;
    logic        push_last;
    logic        full;
    logic        do_pop;
    logic        wr_ok;

    always_comb begin
        rate_eff = (state_q == StIdle) ? bus.rate_half : rate_q;
        ebits    = 3'b000;
        nbits    = 4'd3;
        // ebits is left-aligned in emission order
        if (!rate_eff) begin
            ebits = {bus.sym[0], bus.sym[1], bus.sym[2]};
            nbits = 4'd3;
        end else if (!idx_q[0]) begin
            ebits = {bus.sym[0], bus.sym[1], 1'b0};
            nbits = 4'd2;
        end else begin
            ebits = {bus.sym[0], bus.sym[2], 1'b0};
            nbits = 4'd2;
        end
        // Bits below the fill point of acc_q are always zero, so OR-merging is safe
        ins       = {ebits, 13'b0} >> fill_q;
        wide      = {acc_q, 8'b0} | ins;
        total     = {1'b0, fill_q} + nbits;
        byte_full = (total >= 4'd8);
        last_sym  = (idx_q == IdxW'(FRAME_SYMS - 1));
    end

    // A deferred padded byte never collides with a symbol push: the next frame's
    // first symbol starts from an empty accumulator and cannot fill a byte.
    always_comb begin
        push      = 1'b0;
        push_data = 8'h00;
        push_last = 1'b0;
        if (flush_q) begin
            push      = 1'b1;
            push_data = flush_data_q;
            push_last = 1'b1;
        end else if (bus.sym_valid && (byte_full || last_sym)) begin
            push      = 1'b1;
            push_data = wide[15:8];
            // Padded partial byte, or a full byte that ends exactly on the frame end
            push_last = last_sym && (!byte_full || (total == 4'd8));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            rate_q       <= 1'b0;
            acc_q        <= 8'h00;
            fill_q       <= 3'd0;
            flush_q      <= 1'b0;
            flush_data_q <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= push && push_last;
            flush_q      <= 1'b0;
            if (bus.sym_valid) begin
                if (state_q == StIdle) begin
                    rate_q <= bus.rate_half;
                end
                if (last_sym) begin
                    state_q <= StIdle;
                    idx_q   <= '0;
                    acc_q   <= 8'h00;
                    fill_q  <= 3'd0;
                    // Leftover bits after a full byte go out as a padded byte next cycle
                    if (byte_full && (total != 4'd8)) begin
                        flush_q      <= 1'b1;
                        flush_data_q <= wide[7:0];
                    end
                end else begin
                    state_q <= StActive;
                    idx_q   <= idx_q + IdxW'(1);
                    acc_q   <= byte_full ? wide[7:0] : wide[15:8];
                    fill_q  <= total[2:0];
                end
            end
        end
    end

    always_comb begin
        full   = (count_q == CntW'(FIFO_DEPTH));
        do_pop = (count_q != '0) && bus.out_ready;
        // A pop in the same cycle frees the slot for a push into a full FIFO
        wr_ok  = push && (!full || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 9'h000;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= {push_last, push_data};
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (wr_ok && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!wr_ok && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
            if (push && !wr_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.out_data   = mem_q[rd_ptr_q][7:0];
    assign bus.out_valid  = (count_q != '0);
    assign bus.out_last   = (count_q != '0) && mem_q[rd_ptr_q][8];
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = count_q;
endmodule

// File: doc/turbo_frame_packer.md
# turbo_frame_packer

Downstream stage of the turbo encoder. Consumes one 3-bit encoded symbol per cycle ({parity2, parity1, systematic}), applies selectable rate-1/3 or rate-1/2 puncturing, and packs the surviving bits MSB-first into bytes. Completed bytes go into a small first-word-fall-through FIFO with a valid/ready output and a per-frame last flag, ready for a byte-wide link or memory writer.

## Interface
- FRAME_SYMS, 8, symbols per frame (≥1)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high; clock clk
- sym_valid  in  1  sym is valid this cycle; gaps allowed
- sym  in  3  [0]=systematic, [1]=parity1, [2]=parity2
- rate_half  in  1  1 = rate 1/2, 0 = rate 1/3; sampled on the first symbol of a frame
- out_data  out  8  FIFO head byte
- out_valid  out  1  FIFO not empty
- out_last  out  1  head byte is the final byte of its frame
- out_ready  in  1  consumer accepts the head byte when out_valid=1
- frame_done  out  1  one-cycle pulse when a frame's final byte is pushed
- overflow  out  1  sticky; a byte was dropped because the FIFO was full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Two states:
  - IDLE: symbol index 0. An accepted symbol latches rate_half into the frame rate register and moves to ACTIVE.
  - ACTIVE: counts accepted symbols. The symbol with index FRAME_SYMS-1 ends the frame and returns to IDLE. FRAME_SYMS=1 stays in IDLE.
- Puncturing, in the order bits are emitted:
  - rate 1/3: sys, p1, p2 (3 bits).
  - rate 1/2, even symbol index: sys, p1 (2 bits).
  - rate 1/2, odd symbol index: sys, p2 (2 bits).
- Packing:
  - 8-bit accumulator plus a 3-bit fill count. The first emitted bit lands in bit 7.
  - When fill + n ≥ 8, the full byte is pushed and the leftover fill + n − 8 bits carry into the next byte.
  - At most one push per cycle.
- Frame end:
  - If the fill is nonzero after the final symbol's bits, the partial byte is zero-padded in its low bits and pushed with last=1. Fill resets to 0.
  - If the fill is exactly 0, the byte completed by the final symbol carries last=1.
- FIFO:
  - Entries are {last, data}.
  - Push on byte completion. Pop when out_valid && out_ready.
  - Push while full: the byte is dropped and overflow is set. The frame state still advances.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Pop while empty: ignored.
- sym_valid=0: no state change. rate_half changes mid-frame are ignored.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, frame_done=0, overflow=0, fifo_count=0. State is IDLE, fill is 0, FIFO is empty.
- A symbol accepted at edge N that completes a byte gives out_valid=1 (if the FIFO was empty) and the updated fifo_count after edge N.
- frame_done is high for exactly the one cycle after the edge that pushes the last byte, even if that byte is dropped.
- out_data and out_last are stable while out_valid=1 and out_ready=0.
- Reset mid-frame: the partial accumulator, symbol index, FIFO contents and overflow are all discarded. The next accepted symbol starts a new frame at index 0.

## Test plan
- Rate 1/3 with defaults, 8 symbols of 3'b001, out_ready=1: expect bytes 0x92, 0x49, 0x24, with out_last only on 0x24 and one frame_done pulse.
- Rate 1/2 with defaults, 8 symbols of 3'b011: expect 0xEE then 0xEE (last=1). Toggling rate_half mid-frame does not change this.
- FRAME_SYMS=3, rate 1/3, 3 symbols of 3'b111: expect 0xFF (last=0) then 0x80 (last=1) from zero-padding.
- Defaults, out_ready=0, 14 consecutive rate-1/3 symbols of 3'b001 (bytes 0x92, 0x49, 0x24, 0x92, then 0x49 dropped):
  - fifo_count reaches 4 after symbol 11.
  - overflow rises after symbol 14 and stays high.
  - With out_ready=1, the bench drains 0x92, 0x49, 0x24, 0x92 in order.
- FIFO full plus a new byte completion in the same cycle as out_ready=1: the head pops, the new byte is stored, fifo_count stays 4, overflow stays 0.
- Five symbols, then rst for one cycle, then a clean 8-symbol rate-1/3 frame of 3'b001: output is exactly 0x92, 0x49, 0x24, with no residual bits and overflow=0.
